apb_slave_ws: RTL

APB completer (slave) with a LOCATION-deep register file, programmable wait-state insertion and address-range error signalling. It sits directly downstream of the apb_top requester and consumes its PSEL/PENABLE/PWRITE/PADDR/PWDATA stream. It returns PRDATA, PREADY and PSLVERR, which exercise the requester's wait and error paths.

---
 rtl/apb_slave_ws.sv | 136 +++++++++++++
 1 files changed

// File: rtl/apb_slave_ws.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_ws
//  Purpose  : APB completer with a LOCATION-word register file, a fixed number
//             of wait states per transfer and PSLVERR for out-of-range addresses.
//  Revision : 1.0  initial release
// ============================================================================
module apb_slave_ws #(
    parameter int ADDRESS     = 8,
    parameter int DATA        = 8,
    parameter int LOCATION    = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [ADDRESS-1:0] PADDR,
    input  logic [DATA-1:0]    PWDATA,
    output logic [DATA-1:0]    PRDATA,
    output logic               PREADY,
    output logic               PSLVERR
);

    localparam int             IDX_W     = (LOCATION > 1) ? $clog2(LOCATION) : 1;
    localparam logic [ADDRESS:0] LOC_LIMIT = (ADDRESS+1)'(LOCATION);
    localparam logic [3:0]     CNT_LOAD  = 4'(WAIT_CYCLES);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic             wr_q, wr_d;
    logic             oor_q, oor_d;
    logic [DATA-1:0]  prdata_q, prdata_d;
    logic [DATA-1:0]  mem_q [LOCATION];

    logic             setup;
    logic             oor;
    logic             mem_we;
    logic [IDX_W-1:0] paddr_idx;

    assign setup     = PSEL & ~PENABLE;
    assign oor       = ({1'b0, PADDR} >= LOC_LIMIT);
    assign paddr_idx = PADDR[IDX_W-1:0];

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a setup seen in ACCESS keeps us in ACCESS and restarts
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (setup) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!PSEL)                          state_d = ST_IDLE;
                else if (PENABLE && cnt_q == 4'd0)  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs depend on registered state only
    always_comb begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        if (state_q == ST_ACCESS && cnt_q == 4'd0) begin
            PREADY  = 1'b1;
            PSLVERR = oor_q;
        end
    end

    assign PRDATA = prdata_q;

    always_comb begin
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        oor_d    = oor_q;
        prdata_d = prdata_q;
        mem_we   = 1'b0;
        if (setup) begin
            cnt_d    = CNT_LOAD;
            addr_d   = paddr_idx;
            wr_d     = PWRITE;
            oor_d    = oor;
            prdata_d = (!PWRITE && !oor) ? mem_q[paddr_idx] : '0;
        end else if (state_q == ST_ACCESS && PSEL && PENABLE) begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                mem_we = wr_q & ~oor_q;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            oor_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            oor_q    <= oor_d;
            prdata_q <= prdata_d;
        end
    end

    // Write data is taken live at the completion edge, not from setup
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < LOCATION; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[addr_q] <= PWDATA;
        end
    end

endmodule
`default_nettype wire
